cac_tx_serializer: RTL and testbench

//  Upstream feeder for the 4-wire Fibonacci CAC coder (CACcoder_4) on the TSV link.

---
 rtl/cac_link_pkg.sv | 17 +
 rtl/cac_chunk_shifter.sv | 40 ++++
 rtl/cac_tx_serializer.sv | 122 ++++++++++++
 tb/tb_cac_tx_serializer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cac_link_pkg.sv
// Shared definitions for the CAC TSV link serializer/deserializer pair.
// Holds the 4-wire FTF codeword budget, a sizing helper and the FSM states.
package cac_link_pkg;

  // Legal forbidden-transition-free codewords on a 4-wire Fibonacci bundle
  localparam int CAC4_CODEWORDS = 8;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/cac_chunk_shifter.sv
// Loadable right-shift register that holds the not-yet-sent chunks of a word.
// head is the chunk that will be shown next; idx counts the chunk on the bus.
module cac_chunk_shifter #(
  parameter int WORD_W  = 16,
  parameter int CHUNK_W = 3,
  parameter int NCHUNK  = 6,
  parameter int IDX_W   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [WORD_W-1:0]  data,
  output logic [CHUNK_W-1:0] head,
  output logic [IDX_W-1:0]   idx,
  output logic               last
);

  localparam int SH_W = NCHUNK * CHUNK_W;

  logic [SH_W-1:0] sh;

  // Chunk 0 leaves straight from data on load, so only the rest is kept
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh  <= '0;
      idx <= '0;
    end else if (load) begin
      sh  <= SH_W'(data) >> CHUNK_W;
      idx <= '0;
    end else if (shift) begin
      sh  <= sh >> CHUNK_W;
      idx <= idx + 1'b1;
    end
  end

  assign head = sh[CHUNK_W-1:0];
  assign last = (idx == IDX_W'(NCHUNK - 1));

endmodule

// File: rtl/cac_tx_serializer.sv
// Slices wide words into CHUNK_W-bit chunks, LSB first, for the CAC coder.
// Idle cycles hold IDLE_CODE so the TSV bundle always carries a legal codeword.
module cac_tx_serializer
  import cac_link_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int CHUNK_W   = 3,
  parameter int BLEN      = 4,
  parameter int IDLE_CODE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BLEN-1:0]   coder_data,
  output logic              coder_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic [15:0]       words_sent
);

  localparam int NCHUNK = ceil_div(WORD_W, CHUNK_W);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (CHUNK_W > BLEN) begin : g_chk_blen
    $error("CHUNK_W exceeds coder datain width");
  end
  if ((1 << CHUNK_W) > CAC4_CODEWORDS) begin : g_chk_cw
    $error("CHUNK_W needs more codewords than the coder has");
  end
  if (IDLE_CODE >= (1 << CHUNK_W)) begin : g_chk_idle
    $error("IDLE_CODE does not fit in a chunk");
  end

  ser_state_t         state;
  ser_state_t         state_next;
  logic               load;
  logic               shift;
  logic               xfer;
  logic               last;
  logic [CHUNK_W-1:0] head;
  logic [IDX_W-1:0]   idx;

  assign xfer = in_valid && in_ready;

  cac_chunk_shifter #(
    .WORD_W  (WORD_W),
    .CHUNK_W (CHUNK_W),
    .NCHUNK  (NCHUNK),
    .IDX_W   (IDX_W)
  ) u_shifter (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .data  (in_data),
    .head  (head),
    .idx   (idx),
    .last  (last)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: stay in SEND while chunks remain or a new word arrives
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (xfer) state_next = SEND;
      SEND: if (last && !xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and shifter controls; ready only once the last chunk is up
  always_comb begin
    in_ready = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    if (!reset) begin
      in_ready = (state == IDLE) || last;
    end
    load  = in_valid && in_ready;
    shift = (state == SEND) && !last;
  end

  // Registered coder-side outputs and the completed-word counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      coder_data  <= BLEN'(IDLE_CODE);
      coder_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      words_sent  <= '0;
    end else begin
      if (state == SEND && last) begin
        words_sent <= words_sent + 16'd1;
      end
      if (xfer) begin
        coder_data  <= BLEN'(in_data[CHUNK_W-1:0]);
        coder_valid <= 1'b1;
        frame_start <= 1'b1;
        frame_end   <= (NCHUNK == 1);
      end else if (shift) begin
        coder_data  <= BLEN'(head);
        coder_valid <= 1'b1;
        frame_start <= 1'b0;
        frame_end   <= (int'(idx) == NCHUNK - 2);
      end else begin
        coder_data  <= BLEN'(IDLE_CODE);
        coder_valid <= 1'b0;
        frame_start <= 1'b0;
        frame_end   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cac_tx_serializer.sv
// Self-checking bench for cac_tx_serializer with default parameters.
// A queue of expected bus beats models the word-to-chunk stream.
module tb_cac_tx_serializer;

  localparam int NCH = 6;

  logic        clock;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  coder_data;
  logic        coder_valid;
  logic        frame_start;
  logic        frame_end;
  logic [15:0] words_sent;

  cac_tx_serializer dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .coder_data  (coder_data),
    .coder_valid (coder_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .words_sent  (words_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       s;
    logic       e;
    logic [2:0] c;
  } beat_t;

  beat_t       q[$];
  logic [15:0] m_words;
  int          checks;
  int          failures;
  logic        rdy_seen;
  logic        rdy_exp;
  logic        m_xfer;
  logic [22:0] exp_v;

  function automatic logic [22:0] obs();
    return {coder_valid, frame_start, frame_end, coder_data, words_sent};
  endfunction

  function automatic logic [22:0] model_out();
    beat_t b;
    if (q.size() == 0) return {3'b000, 4'd0, m_words};
    b = q[0];
    return {1'b1, b.s, b.e, 1'b0, b.c, m_words};
  endfunction

  // Drive one cycle, advance the model across the edge
  task automatic cycle(input logic v, input logic [15:0] d);
    beat_t b;
    in_valid = v;
    in_data  = d;
    #1;
    rdy_seen = in_ready;
    rdy_exp  = (q.size() <= 1);
    m_xfer   = v && rdy_exp;
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      b = q.pop_front();
      if (b.e) m_words = m_words + 16'd1;
    end
    if (m_xfer) begin
      for (int k = 0; k < NCH; k++) begin
        b.s = (k == 0);
        b.e = (k == NCH - 1);
        b.c = 3'((d >> (3 * k)) & 16'h7);
        q.push_back(b);
      end
    end
    exp_v = model_out();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    q.delete();
    m_words = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || words_sent !== 16'd0) begin
      failures++;
      $display("FAIL reset_release ready=%b words=%0d want 1 0",
               in_ready, words_sent);
    end
    repeat (3) cycle(1'b0, 16'h0);
    reset = 1'b1;
    #1;
    checks++;
    if (coder_valid !== 1'b0 || coder_data !== 4'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle v=%b d=%0d r=%b want 0 0 0",
               coder_valid, coder_data, in_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    cycle(1'b1, 16'hABCD);
    for (int i = 0; i < NCH + 2; i++) begin
      checks++;
      if (rdy_seen !== rdy_exp || obs() !== exp_v) begin
        failures++;
        $display("FAIL single[%0d] got r=%b %h want r=%b %h",
                 i, rdy_seen, obs(), rdy_exp, exp_v);
      end
      cycle(1'b0, 16'h0);
    end
    checks++;
    if (words_sent !== 16'd1) begin
      failures++;
      $display("FAIL single_count got %0d want 1", words_sent);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    int sent;
    sent = 0;
    for (int i = 0; i < 2 * NCH + 3; i++) begin
      w = (sent == 0) ? 16'h0001 : 16'hFFFF;
      cycle(sent < 2, w);
      if (m_xfer) sent++;
      checks++;
      if (rdy_seen !== rdy_exp || obs() !== exp_v) begin
        failures++;
        $display("FAIL b2b[%0d] got r=%b %h want r=%b %h",
                 i, rdy_seen, obs(), rdy_exp, exp_v);
      end
    end
  endtask

  task automatic test_backpressure();
    logic pend;
    pend = 1'b0;
    cycle(1'b1, 16'($urandom));
    for (int i = 0; i < 2 * NCH + 2; i++) begin
      if (i == 2) pend = 1'b1;
      cycle(pend, 16'h1234);
      if (m_xfer) pend = 1'b0;
      checks++;
      if (rdy_seen !== rdy_exp || obs() !== exp_v) begin
        failures++;
        $display("FAIL bp[%0d] got r=%b %h want r=%b %h",
                 i, rdy_seen, obs(), rdy_exp, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    cycle(1'b1, 16'hABCD);
    cycle(1'b0, 16'h0);
    cycle(1'b0, 16'h0);
    reset = 1'b1;
    q.delete();
    m_words = '0;
    #1;
    checks++;
    if (coder_valid !== 1'b0 || coder_data !== 4'd0 ||
        words_sent !== 16'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset v=%b d=%0d w=%0d r=%b want 0 0 0 0",
               coder_valid, coder_data, words_sent, in_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    cycle(1'b1, 16'h0007);
    for (int i = 0; i < NCH + 1; i++) begin
      checks++;
      if (rdy_seen !== rdy_exp || obs() !== exp_v) begin
        failures++;
        $display("FAIL post_reset[%0d] got r=%b %h want r=%b %h",
                 i, rdy_seen, obs(), rdy_exp, exp_v);
      end
      cycle(1'b0, 16'h0);
    end
  endtask

  task automatic test_random();
    logic        v;
    logic [15:0] w;
    v = 1'b0;
    w = '0;
    for (int i = 0; i < 600; i++) begin
      if (!v) begin
        v = ($urandom_range(0, 9) < 7);
        w = 16'($urandom);
      end
      cycle(v, w);
      if (m_xfer) v = 1'b0;
      checks++;
      if (rdy_seen !== rdy_exp || obs() !== exp_v) begin
        failures++;
        $display("FAIL random[%0d] got r=%b %h want r=%b %h",
                 i, rdy_seen, obs(), rdy_exp, exp_v);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
